circle_sequencer: RTL and testbench

Sequences a full "clear screen, then draw one circle" operation onto the VGA adapter's single pixel-write port. It owns the clear-screen scan counters and the Bresenham midpoint-circle state: offsets, decision term and octant index. Each cycle it emits at most one plot with its coordinates and colour. It sits between the top-level task FSM or switches and the VGA adapter.

---
 rtl/circle_pkg.sv | 48 ++++
 rtl/screen_clear_counter.sv | 68 ++++++
 rtl/circle_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_circle_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// circle_pkg
// Shared types and constants for the clear-and-draw-circle sequencer:
//   - state_e      : sequencer FSM states
//   - SCREEN_W_DEF / SCREEN_H_DEF : default screen geometry
//   - coord_x_t / coord_y_t / point_t : pixel coordinate and signed point types
//   - oct_lookup() : per-octant swap flag and x/y negation
package circle_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INIT  = 3'd2,
        ST_OCT   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef logic [7:0]        coord_x_t;
    typedef logic [6:0]        coord_y_t;
    typedef logic signed [9:0] point_t;

    // swap: use (oy, ox) instead of (ox, oy); neg_x/neg_y: subtract from centre
    typedef struct packed {
        logic swap;
        logic neg_x;
        logic neg_y;
    } oct_entry_t;

    function automatic oct_entry_t oct_lookup(input logic [2:0] k);
        oct_entry_t e;
        case (k)
            3'd0:    e = '{swap: 1'b0, neg_x: 1'b0, neg_y: 1'b0};
            3'd1:    e = '{swap: 1'b1, neg_x: 1'b0, neg_y: 1'b0};
            3'd2:    e = '{swap: 1'b0, neg_x: 1'b1, neg_y: 1'b0};
            3'd3:    e = '{swap: 1'b1, neg_x: 1'b1, neg_y: 1'b0};
            3'd4:    e = '{swap: 1'b0, neg_x: 1'b1, neg_y: 1'b1};
            3'd5:    e = '{swap: 1'b1, neg_x: 1'b1, neg_y: 1'b1};
            3'd6:    e = '{swap: 1'b0, neg_x: 1'b0, neg_y: 1'b1};
            3'd7:    e = '{swap: 1'b1, neg_x: 1'b0, neg_y: 1'b1};
            default: e = '{swap: 1'b0, neg_x: 1'b0, neg_y: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/screen_clear_counter.sv
// screen_clear_counter
// Raster scan counter for the clear phase: x is the inner index, y the outer.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clr_i        : synchronous return to (0,0)
//   en_i         : advance one pixel
//   x_o, y_o     : current pixel
//   last_o       : current pixel is the bottom-right corner
module screen_clear_counter
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clr_i,
    input  logic     en_i,
    output coord_x_t x_o,
    output coord_y_t y_o,
    output logic     last_o
);

    localparam coord_x_t X_MAX = coord_x_t'(SCREEN_W - 1);
    localparam coord_y_t Y_MAX = coord_y_t'(SCREEN_H - 1);

    coord_x_t x_q, x_d;
    coord_y_t y_q, y_d;

    // Next pixel: wrap x at the right edge and step y; wrap y at the bottom
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = 8'd0;
            y_d = 7'd0;
        end else if (en_i) begin
            if (x_q == X_MAX) begin
                x_d = 8'd0;
                if (y_q == Y_MAX) begin
                    y_d = 7'd0;
                end else begin
                    y_d = y_q + 7'd1;
                end
            end else begin
                x_d = x_q + 8'd1;
            end
        end else begin
            x_d = x_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= 8'd0;
            y_q <= 7'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/circle_sequencer.sv
// circle_sequencer
// Clears the screen, then draws one midpoint circle, emitting at most one
// pixel write per cycle to the VGA adapter.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, honoured only in IDLE or DONE
//   centre_x/centre_y   : circle centre, latched on accepted start
//   radius, colour_in   : circle radius and colour, latched on accepted start
//   x, y, colour, plot  : pixel write port (all valid when plot=1)
//   busy                : CLEAR through STEP
//   done                : DONE until the next accepted start
module circle_sequencer
    import circle_pkg::*;
#(
    parameter int         SCREEN_W     = SCREEN_W_DEF,
    parameter int         SCREEN_H     = SCREEN_H_DEF,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [6:0] radius,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam point_t W_LIM = point_t'(SCREEN_W);
    localparam point_t H_LIM = point_t'(SCREEN_H);

    state_e              state_q, state_d;
    coord_x_t            cx_q, cx_d;
    coord_y_t            cy_q, cy_d;
    logic [6:0]          rad_q, rad_d;
    logic [2:0]          col_q, col_d;
    logic signed [8:0]   ox_q, ox_d;
    logic signed [8:0]   oy_q, oy_d;
    logic signed [9:0]   crit_q, crit_d;
    logic [2:0]          k_q, k_d;

    logic                start_ok_s;
    logic                clr_en_s;
    coord_x_t            clr_x_s;
    coord_y_t            clr_y_s;
    logic                clr_last_s;

    logic signed [8:0]   oy_new_s, ox_new_s;
    logic signed [9:0]   oy_w_s, ox_w_s;

    oct_entry_t          oct_s;
    logic signed [9:0]   dx_s, dy_s;
    point_t              px_s, py_s;
    logic                on_screen_s;

    assign clr_en_s = (state_q == ST_CLEAR);

    screen_clear_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start_ok_s),
        .en_i   (clr_en_s),
        .x_o    (clr_x_s),
        .y_o    (clr_y_s),
        .last_o (clr_last_s)
    );

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        rad_d      = rad_q;
        col_d      = col_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        crit_d     = crit_q;
        k_d        = k_q;
        start_ok_s = 1'b0;
        oy_new_s   = oy_q + 9'sd1;
        ox_new_s   = ox_q;
        oy_w_s     = 10'sd0;
        ox_w_s     = 10'sd0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok_s = 1'b1;
                    cx_d       = centre_x;
                    cy_d       = centre_y;
                    rad_d      = radius;
                    col_d      = colour_in;
                    state_d    = ST_CLEAR;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_INIT: begin
                ox_d    = $signed({2'b00, rad_q});
                oy_d    = 9'sd0;
                crit_d  = 10'sd1 - $signed({3'b000, rad_q});
                k_d     = 3'd0;
                state_d = ST_OCT;
            end
            ST_OCT: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_OCT;
                end
            end
            ST_STEP: begin
                // Decision update uses the already-stepped offsets
                if (crit_q <= 10'sd0) begin
                    ox_new_s = ox_q;
                    oy_w_s   = {oy_new_s[8], oy_new_s};
                    crit_d   = crit_q + (oy_w_s <<< 1'b1) + 10'sd1;
                end else begin
                    ox_new_s = ox_q - 9'sd1;
                    oy_w_s   = {oy_new_s[8], oy_new_s};
                    ox_w_s   = {ox_new_s[8], ox_new_s};
                    crit_d   = crit_q + ((oy_w_s - ox_w_s) <<< 1'b1) + 10'sd1;
                end
                ox_d = ox_new_s;
                oy_d = oy_new_s;
                k_d  = 3'd0;
                if (oy_new_s <= ox_new_s) begin
                    state_d = ST_OCT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and circle registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
            rad_q   <= 7'd0;
            col_q   <= 3'd0;
            ox_q    <= 9'sd0;
            oy_q    <= 9'sd0;
            crit_q  <= 10'sd0;
            k_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rad_q   <= rad_d;
            col_q   <= col_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            crit_q  <= crit_d;
            k_q     <= k_d;
        end
    end

    // Octant point: centre plus the (possibly swapped, possibly negated) offsets
    always_comb begin
        oct_s = oct_lookup(k_q);
        if (oct_s.swap) begin
            dx_s = {oy_q[8], oy_q};
            dy_s = {ox_q[8], ox_q};
        end else begin
            dx_s = {ox_q[8], ox_q};
            dy_s = {oy_q[8], oy_q};
        end
        if (oct_s.neg_x) begin
            px_s = $signed({2'b00, cx_q}) - dx_s;
        end else begin
            px_s = $signed({2'b00, cx_q}) + dx_s;
        end
        if (oct_s.neg_y) begin
            py_s = $signed({3'b000, cy_q}) - dy_s;
        end else begin
            py_s = $signed({3'b000, cy_q}) + dy_s;
        end
        on_screen_s = (px_s >= 10'sd0) && (px_s < W_LIM) &&
                      (py_s >= 10'sd0) && (py_s < H_LIM);
    end

    // Moore output decode from the registered state and counters
    always_comb begin
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'd0;
        plot   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                x      = clr_x_s;
                y      = clr_y_s;
                colour = CLEAR_COLOUR;
                plot   = 1'b1;
                busy   = 1'b1;
            end
            ST_INIT: begin
                busy = 1'b1;
            end
            ST_OCT: begin
                x      = px_s[7:0];
                y      = py_s[6:0];
                colour = col_q;
                plot   = on_screen_s;
                busy   = 1'b1;
            end
            ST_STEP: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_circle_sequencer.sv
// Scoreboard bench for circle_sequencer: stimulus pushes expected plots and
// expected status snapshots (keyed by cycle) into queues; one monitor on the
// falling edge pops and compares them against the DUT.
module tb_circle_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [6:0] radius;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    circle_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .centre_x  (centre_x),
        .centre_y  (centre_y),
        .radius    (radius),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;

    typedef struct {
        int   cyc;
        logic busy;
        logic done;
        logic plot;
        logic zero;
    } stat_t;

    plot_t pq[$];
    stat_t sq[$];

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  finish_req = 1'b0;

    // r=1 at (80,60): two iterations of eight octant points
    int b_x [16] = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
    int b_y [16] = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};
    // r=5 at (0,0): only on-screen points, with their iteration and octant
    int c_it [10] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3};
    int c_k  [10] = '{0, 1, 3, 6, 0, 1, 0, 1, 0, 1};
    int c_x  [10] = '{5, 0, 0, 5, 5, 1, 5, 2, 4, 3};
    int c_y  [10] = '{0, 5, 5, 0, 1, 5, 2, 5, 3, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_clear(input int t0, input int n);
        plot_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = t0 + 1 + i;
            e.x   = 8'(i % 160);
            e.y   = 7'(i / 160);
            e.c   = 3'b000;
            pq.push_back(e);
        end
    endtask

    task automatic push_oct(input int t0, input int it, input int k,
                            input int px, input int py, input logic [2:0] c);
        plot_t e;
        e.cyc = t0 + 19202 + 9 * it + k;
        e.x   = 8'(px);
        e.y   = 7'(py);
        e.c   = c;
        pq.push_back(e);
    endtask

    task automatic push_st(input int c, input logic b, input logic d,
                           input logic p, input logic z);
        stat_t s;
        s.cyc  = c;
        s.busy = b;
        s.done = d;
        s.plot = p;
        s.zero = z;
        sq.push_back(s);
    endtask

    // Monitor: plot scoreboard, status snapshots, end-of-run and timeout
    always @(negedge clk) begin
        plot_t e;
        stat_t s;
        if (plot === 1'b1) begin
            n_checks++;
            if (pq.size() == 0) begin
                n_fail++;
                $display("FAIL plot_unexpected cyc=%0d got (%0d,%0d) c=%0d, required no plot",
                         cyc, x, y, colour);
            end else begin
                e = pq.pop_front();
                if (x !== e.x || y !== e.y || colour !== e.c || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL plot_value got (%0d,%0d) c=%0d at cyc %0d, required (%0d,%0d) c=%0d at cyc %0d",
                             x, y, colour, cyc, e.x, e.y, e.c, e.cyc);
                end
            end
        end else if (pq.size() != 0 && pq[0].cyc <= cyc) begin
            e = pq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL plot_missing cyc=%0d plot=%b, required (%0d,%0d) c=%0d at cyc %0d",
                     cyc, plot, e.x, e.y, e.c, e.cyc);
        end
        while (sq.size() != 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            n_checks++;
            if (busy !== s.busy || done !== s.done || plot !== s.plot ||
                (s.zero && (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0))) begin
                n_fail++;
                $display("FAIL status cyc=%0d got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, required busy=%b done=%b plot=%b%s",
                         cyc, busy, done, plot, x, y, colour, s.busy, s.done, s.plot,
                         s.zero ? " x=0 y=0 c=0" : "");
            end
        end
        if (finish_req) begin
            n_checks++;
            if (pq.size() != 0 || sq.size() != 0) begin
                n_fail++;
                $display("FAIL queues_drained got %0d plots and %0d status entries left, required 0 and 0",
                         pq.size(), sq.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end else if (cyc > 80000) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout cyc=%0d, required end of stimulus before cycle 80000", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    int t0, ta, tb, tc;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        centre_x  = 8'd0;
        centre_y  = 7'd0;
        radius    = 7'd0;
        colour_in = 3'd0;
        push_st(3, 1'b0, 1'b0, 1'b0, 1'b1);
        at_cycle(4);
        reset = 1'b0;

        // Reset in mid-clear
        at_cycle(10);
        t0 = cyc;
        centre_x = 8'd40; centre_y = 7'd30; radius = 7'd3; colour_in = 3'b111;
        start = 1'b1;
        push_clear(t0, 5000);
        push_st(t0 + 5000, 1'b1, 1'b0, 1'b1, 1'b0);
        push_st(t0 + 5001, 1'b0, 1'b0, 1'b0, 1'b1);
        push_st(t0 + 5003, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        at_cycle(t0 + 5000);
        reset = 1'b1;
        at_cycle(t0 + 5001);
        reset = 1'b0;

        // Run A: r=0 at (80,60), with ignored starts in CLEAR and OCT
        at_cycle(t0 + 5005);
        ta = cyc;
        centre_x = 8'd80; centre_y = 7'd60; radius = 7'd0; colour_in = 3'b010;
        start = 1'b1;
        push_clear(ta, 19200);
        for (int k = 0; k < 8; k++) push_oct(ta, 0, k, 80, 60, 3'b010);
        push_st(ta + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_st(ta + 19201, 1'b1, 1'b0, 1'b0, 1'b0);
        push_st(ta + 19210, 1'b1, 1'b0, 1'b0, 1'b0);
        push_st(ta + 19211, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        at_cycle(ta + 100);
        centre_x = 8'd3; centre_y = 7'd3; radius = 7'd9; colour_in = 3'b111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        at_cycle(ta + 19203);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Run B: start in DONE, r=1 at (80,60); start then held high
        at_cycle(ta + 19211);
        tb = cyc;
        centre_x = 8'd80; centre_y = 7'd60; radius = 7'd1; colour_in = 3'b110;
        start = 1'b1;
        push_clear(tb, 19200);
        for (int i = 0; i < 16; i++) push_oct(tb, i / 8, i % 8, b_x[i], b_y[i], 3'b110);
        push_st(tb + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_st(tb + 19219, 1'b1, 1'b0, 1'b0, 1'b0);
        push_st(tb + 19220, 1'b0, 1'b1, 1'b0, 1'b1);
        at_cycle(tb + 2);
        centre_x = 8'd0; centre_y = 7'd0; radius = 7'd5; colour_in = 3'b101;

        // Run C: held start restarts on DONE entry; r=5 at (0,0) clips
        at_cycle(tb + 19220);
        tc = cyc;
        push_clear(tc, 19200);
        for (int i = 0; i < 10; i++) push_oct(tc, c_it[i], c_k[i], c_x[i], c_y[i], 3'b101);
        push_st(tc + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_st(tc + 19237, 1'b1, 1'b0, 1'b0, 1'b0);
        push_st(tc + 19238, 1'b0, 1'b1, 1'b0, 1'b1);
        push_st(tc + 19245, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;

        at_cycle(tc + 19250);
        finish_req = 1'b1;
    end

endmodule
